// File: rtl/xor_mlp_seq.sv
// xor_mlp_seq: sequential fixed-point 2-input MLP inference engine.
// One time-shared signed multiplier evaluates HIDDEN ReLU neurons followed by
// one linear output neuron. Weights are written at runtime while idle.
// Optional build macro: XOR_MLP_SAT_EN selects saturating narrowing of
// neuron results; without it results wrap to the low W bits.
module xor_mlp_seq #(
  parameter int W         = 32,
  parameter int FRAC_BITS = 8,
  parameter int HIDDEN    = 2,
  parameter int ACC_GUARD = 8,
  localparam int NW       = 4*HIDDEN+1,
  localparam int AW       = $clog2(NW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x0,
  input  logic [W-1:0]  in_x1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic          out_class,
  output logic          busy
);

  localparam int ACCW = W + ACC_GUARD;
  localparam int PW   = 2 * W;
  localparam int JW   = $clog2(HIDDEN+1);
  localparam logic signed [W-1:0] HALF = W'(1) << (FRAC_BITS-1);

  typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [JW-1:0]          j_q, j_d;
  logic [1:0]             ph_q, ph_d;
  logic signed [W-1:0]    x0_q, x0_d, x1_q, x1_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [W-1:0]    h_q [HIDDEN];
  logic signed [W-1:0]    w_q [NW];
  logic signed [W-1:0]    y_q, y_d;
  logic                   cls_q, cls_d;
  logic                   h_we;
  logic signed [W-1:0]    h_wdata, y_red;

  int                     widx;
  logic signed [W-1:0]    mul_a, wsel, hsel;
  logic signed [PW-1:0]   mul_a_ext, mul_b_ext, prod, prod_sh;
  logic signed [ACCW-1:0] term, bias_ext, bias_sum;

  function automatic logic signed [ACCW-1:0] relu(input logic signed [ACCW-1:0] v);
    return v[ACCW-1] ? '0 : v;
  endfunction

  function automatic logic signed [W-1:0] reduce(input logic signed [ACCW-1:0] v);
`ifdef XOR_MLP_SAT_EN
    logic signed [ACCW-1:0] maxv, minv;
    maxv = {{(ACC_GUARD+1){1'b0}}, {(W-1){1'b1}}};
    minv = {{(ACC_GUARD+1){1'b1}}, {(W-1){1'b0}}};
    if (v > maxv)      return maxv[W-1:0];
    else if (v < minv) return minv[W-1:0];
    else               return v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  // Operand selection for the shared multiplier; weight index also picks biases.
  always_comb begin
    mul_a = x0_q;
    widx  = 3*int'(j_q) + int'(ph_q);
    if (state_q == S_HID && ph_q == 2'd1) mul_a = x1_q;
    if (state_q == S_OUT) begin
      widx  = 3*HIDDEN + int'(j_q);
      mul_a = hsel;
    end
  end

  // Weight and hidden-activation read muxes.
  always_comb begin
    wsel = '0;
    hsel = '0;
    for (int k = 0; k < NW; k++)
      if (widx == k) wsel = w_q[k];
    for (int k = 0; k < HIDDEN; k++)
      if (int'(j_q) == k) hsel = h_q[k];
  end

  // Full-width signed product, floor-scaled and wrapped into accumulator width.
  always_comb begin
    mul_a_ext = PW'(mul_a);
    mul_b_ext = PW'(wsel);
    prod      = mul_a_ext * mul_b_ext;
    prod_sh   = prod >>> FRAC_BITS;
    term      = ACCW'(prod_sh);
    bias_ext  = ACCW'(wsel);
    bias_sum  = acc_q + bias_ext;
  end

  // Next-state and datapath sequencing for IDLE -> HID -> OUT -> DONE.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    ph_d    = ph_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    acc_d   = acc_q;
    y_d     = y_q;
    cls_d   = cls_q;
    h_we    = 1'b0;
    h_wdata = reduce(relu(bias_sum));
    y_red   = reduce(bias_sum);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x0_d    = $signed(in_x0);
          x1_d    = $signed(in_x1);
          acc_d   = '0;
          j_d     = '0;
          ph_d    = '0;
          state_d = S_HID;
        end
      end
      S_HID: begin
        if (ph_q != 2'd2) begin
          acc_d = acc_q + term;
          ph_d  = ph_q + 2'd1;
        end else begin
          h_we  = 1'b1;
          acc_d = '0;
          ph_d  = '0;
          if (int'(j_q) == HIDDEN-1) begin
            j_d     = '0;
            state_d = S_OUT;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_OUT: begin
        if (int'(j_q) < HIDDEN) begin
          acc_d = acc_q + term;
          j_d   = j_q + 1'b1;
        end else begin
          y_d     = y_red;
          cls_d   = (y_red >= HALF);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, weights and result registers; reset aborts any inference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      ph_q    <= '0;
      y_q     <= '0;
      cls_q   <= 1'b0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      ph_q    <= ph_d;
      y_q     <= y_d;
      cls_q   <= cls_d;
      for (int k = 0; k < NW; k++)
        if (cfg_we && state_q == S_IDLE && int'(cfg_addr) == k) w_q[k] <= cfg_wdata;
    end
  end

  // Working data registers; their contents are only meaningful inside an inference.
  always_ff @(posedge clk) begin
    x0_q  <= x0_d;
    x1_q  <= x1_d;
    acc_q <= acc_d;
    for (int k = 0; k < HIDDEN; k++)
      if (h_we && int'(j_q) == k) h_q[k] <= h_wdata;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_y     = y_q;
  assign out_class = cls_q;

endmodule

// File: tb/tb_xor_mlp_seq.sv
// Self-checking bench for xor_mlp_seq (default parameters) against a
// plain-arithmetic model of the network.
module tb_xor_mlp_seq;
  localparam int W  = 32;
  localparam int NW = 9;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_wdata = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x0 = '0;
  logic [W-1:0]  in_x1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_y;
  logic          out_class;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int wm[NW];

  xor_mlp_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_x1(in_x1),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_class(out_class), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 40-bit accumulator wrap
  function automatic longint wrapa(input longint v);
    return (v <<< 24) >>> 24;
  endfunction

  function automatic longint red(input longint v);
`ifdef XOR_MLP_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    return longint'(int'(v));
`endif
  endfunction

  function automatic longint model(input int x0, input int x1);
    longint h[2];
    longint a;
    for (int j = 0; j < 2; j++) begin
      a = 0;
      a = wrapa(a + ((longint'(x0) * longint'(wm[3*j])) >>> 8));
      a = wrapa(a + ((longint'(x1) * longint'(wm[3*j+1])) >>> 8));
      a = wrapa(a + longint'(wm[3*j+2]));
      if (a < 0) a = 0;
      h[j] = red(a);
    end
    a = 0;
    for (int j = 0; j < 2; j++)
      a = wrapa(a + ((h[j] * longint'(wm[6+j])) >>> 8));
    a = wrapa(a + longint'(wm[8]));
    return red(a);
  endfunction

  task automatic wr(input int a, input int d, input bit commit);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (commit && a < NW) wm[a] = d;
  endtask

  task automatic load_xor();
    int xw[NW];
    xw = '{256, 256, 0, 256, 256, -256, 256, -512, 0};
    for (int i = 0; i < NW; i++) wr(i, xw[i], 1'b1);
  endtask

  task automatic run_sample(input int x0, input int x1, input bit mid_wr,
                            output logic signed [63:0] got);
    logic signed [63:0] exp;
    int edges;
    @(negedge clk);
    in_x0 = x0; in_x1 = x1; in_valid = 1'b1;
    check("idle_ready", in_ready, 1);
    exp = model(x0, x1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      cfg_we = (mid_wr && edges == 2);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      edges++;
    end
    check("latency", edges, 9);
    check("out_y", $signed(out_y), exp);
    check("out_class", out_class, (exp >= 128));
    got = $signed(out_y);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("post_hs_ready", in_ready, 1);
    check("post_hs_valid", out_valid, 0);
  endtask

  initial begin
    logic signed [63:0] got, exp;
    int edges, pulses, na, nr, cyc;
    bit took;
    int bx0[8], bx1[8], acc_cyc[8];
    logic signed [63:0] q[$];
    int tx0[4], tx1[4], ty[4];

    for (int i = 0; i < NW; i++) wm[i] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_y", $signed(out_y), 0);
    check("rst_out_class", out_class, 0);
    @(negedge clk); rst_n = 1'b1;

    // XOR truth table
    load_xor();
    tx0 = '{0, 256, 0, 256}; tx1 = '{0, 0, 256, 256}; ty = '{0, 256, 256, 0};
    for (int i = 0; i < 4; i++) begin
      run_sample(tx0[i], tx1[i], 1'b0, got);
      check("xor_table", got, ty[i]);
    end

    // Out-of-range config addresses are ignored
    for (int a = NW; a < 16; a++) wr(a, 12345, 1'b0);
    run_sample(256, 0, 1'b0, got);
    check("oob_addr", got, 256);

    // Backpressure in DONE
    @(negedge clk);
    in_x0 = 0; in_x1 = 256; in_valid = 1'b1;
    exp = model(0, 256);
    @(posedge clk); #1; in_valid = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    check("bp_latency", edges, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_x0 = 256; in_x1 = 256;
      check("bp_y_stable", $signed(out_y), exp);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    @(posedge clk); #1;
    check("bp_idle_busy", busy, 0);

    // Writes while busy are dropped; writes while idle commit
    cfg_addr = AW'(1); cfg_wdata = 0;
    run_sample(0, 256, 1'b1, got);
    check("busy_write_dropped", got, 256);
    wr(1, 0, 1'b1);
    run_sample(0, 256, 1'b0, got);
    check("idle_write_commit", got, 0);

    // Reset mid-inference aborts
    load_xor();
    run_sample(256, 0, 1'b0, got);
    @(negedge clk); in_x0 = 256; in_x1 = 0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check("abort_out_y", $signed(out_y), 0);
    check("abort_class", out_class, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    for (int i = 0; i < NW; i++) wm[i] = 0;

    // Narrowing overflow
    for (int i = 0; i < NW; i++) wr(i, 0, 1'b1);
    wr(0, 1 << 30, 1'b1);
    wr(6, 256, 1'b1);
    run_sample(65536, 0, 1'b0, got);
`ifdef XOR_MLP_SAT_EN
    check("overflow_sat", got, 2147483647);
`else
    check("overflow_wrap", got, 0);
`endif

    // Randomized weights and samples
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NW; i++)
        wr(i, (it < 5) ? int'($urandom_range(0, 8192)) - 4096 : int'($urandom()), 1'b1);
      run_sample((it < 5) ? int'($urandom_range(0, 8192)) - 4096 : int'($urandom()),
                 (it < 5) ? int'($urandom_range(0, 8192)) - 4096 : int'($urandom()),
                 1'b0, got);
    end

    // Back-to-back streaming
    load_xor();
    for (int i = 0; i < 8; i++) begin
      bx0[i] = int'($urandom_range(0, 1)) * 256 + int'($urandom_range(0, 40)) - 20;
      bx1[i] = int'($urandom_range(0, 1)) * 256 + int'($urandom_range(0, 40)) - 20;
    end
    na = 0; nr = 0; cyc = 0;
    out_ready = 1'b1;
    in_x0 = bx0[0]; in_x1 = bx1[0]; in_valid = 1'b1;
    while (nr < 8 && cyc < 400) begin
      @(negedge clk);
      took = (in_valid === 1'b1 && in_ready === 1'b1);
      if (took) begin
        q.push_back(model(bx0[na], bx1[na]));
        acc_cyc[na] = cyc;
        na++;
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) check("b2b_spurious", 1, 0);
        else check("b2b_y", $signed(out_y), q.pop_front());
        nr++;
      end
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        if (na < 8) begin in_x0 = bx0[na]; in_x1 = bx1[na]; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_results", nr, 8);
    check("b2b_accepts", na, 8);
    for (int i = 1; i < 8; i++)
      if (i < na) check("b2b_period", acc_cyc[i] - acc_cyc[i-1], 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
